crack_multi_ctrl: RTL

Parametrised multi-lane ARC4 key-search controller, successor to the single-core `crack` block. It sweeps the key space 0 … 2^KEY_W−1 by handing candidate keys to LANES external per-key test lanes (each an ARC4 decrypt-and-check engine). It collects their verdicts and reports the smallest matching key. A sequential cracker would report the same key, so the result does not depend on lane count or lane latency.

---
 rtl/crack_pkg.sv | 20 ++
 rtl/crack_min_sel.sv | 45 ++++
 rtl/crack_multi_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/crack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crack_pkg                                                    |
// | Description : Shared definitions for the ARC4 key-search controllers:      |
// |               controller state encoding and default key width.            |
// | Revision    : 1.0 - initial multi-lane release                             |
// +----------------------------------------------------------------------------+
package crack_pkg;

  // Default candidate key width, shared with the single-core cracker.
  localparam int CRACK_KEY_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } crack_state_e;

endpackage : crack_pkg
`default_nettype wire

// File: rtl/crack_min_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crack_min_sel                                                |
// | Description : Combinational reduction over one cycle of lane verdicts.     |
// |               Reports whether any lane delivered a match and the smallest  |
// |               matching key among them.                                     |
// | Revision    : 1.0 - initial multi-lane release                             |
// |                                                                            |
// | Ports                                                                      |
// |   done_i     [LANES]       verdict strobes (already qualified by caller)   |
// |   match_i    [LANES]       verdict per lane, meaningful with done_i        |
// |   keys_i     [LANES*KEY_W] key evaluated by each lane                      |
// |   any_o                    at least one strobed lane matched              |
// |   min_key_o  [KEY_W]       smallest matching key, 0 when any_o=0          |
// +----------------------------------------------------------------------------+
module crack_min_sel #(
  parameter int LANES = 2,
  parameter int KEY_W = 24
) (
  input  logic [LANES-1:0]       done_i,
  input  logic [LANES-1:0]       match_i,
  input  logic [LANES*KEY_W-1:0] keys_i,
  output logic                   any_o,
  output logic [KEY_W-1:0]       min_key_o
);

  always_comb begin
    logic             found;
    logic [KEY_W-1:0] best;
    found = 1'b0;
    best  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (done_i[i] && match_i[i]) begin
        if (!found || (keys_i[i*KEY_W +: KEY_W] < best)) begin
          best = keys_i[i*KEY_W +: KEY_W];
        end
        found = 1'b1;
      end
    end
    any_o     = found;
    min_key_o = best;
  end

endmodule : crack_min_sel
`default_nettype wire

// File: rtl/crack_multi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crack_multi_ctrl                                             |
// | Description : Multi-lane ARC4 key-search controller. Sweeps keys 0..2^KEY_W-1|
// |               over LANES external test lanes and reports the smallest      |
// |               matching key, independent of lane count and latency.         |
// | Revision    : 1.0 - initial multi-lane release                             |
// |                                                                            |
// | Optional build macro: CRACK_PERF_EN adds the keys_tried_o counter port.    |
// |                                                                            |
// | Ports                                                                      |
// |   clk, rst        clock (rising edge), asynchronous active-high reset      |
// |   en_i            start request, sampled only while rdy_o=1                |
// |   rdy_o           1 = idle, result outputs stable                          |
// |   key_o           smallest matching key of the last search                 |
// |   key_valid_o     key_o holds a found match                                |
// |   lane_rdy_i      lane i can accept a key                                  |
// |   lane_en_o       one-cycle dispatch strobe to lane i                      |
// |   lane_key_o      key for lane i, valid with lane_en_o[i]                  |
// |   lane_done_i     one-cycle verdict strobe from lane i                     |
// |   lane_match_i    verdict of lane i, valid with lane_done_i[i]             |
// |   keys_tried_o    keys dispatched in the current/last search (PERF only)  |
// +----------------------------------------------------------------------------+
module crack_multi_ctrl
  import crack_pkg::*;
#(
  parameter int KEY_W = CRACK_KEY_W,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  output logic                   rdy_o,
  output logic [KEY_W-1:0]       key_o,
  output logic                   key_valid_o,
  input  logic [LANES-1:0]       lane_rdy_i,
  output logic [LANES-1:0]       lane_en_o,
  output logic [LANES*KEY_W-1:0] lane_key_o,
  input  logic [LANES-1:0]       lane_done_i,
  input  logic [LANES-1:0]       lane_match_i
`ifdef CRACK_PERF_EN
  ,
  output logic [KEY_W:0]         keys_tried_o
`endif
);

  crack_state_e           state_q,      state_d;
  logic [KEY_W:0]         next_key_q,   next_key_d;   // MSB set = space exhausted
  logic [LANES-1:0]       busy_q,       busy_d;
  logic [LANES*KEY_W-1:0] inflight_q,   inflight_d;
  logic [KEY_W-1:0]       cand_q,       cand_d;
  logic                   cand_valid_q, cand_valid_d;
  logic [KEY_W-1:0]       key_q,        key_d;
  logic                   key_valid_q,  key_valid_d;

  // Verdicts only count for lanes we actually have a key outstanding on;
  // this also drops strobes left over from a search cut short by reset.
  logic [LANES-1:0]       done_eff;
  logic                   sel_any;
  logic [KEY_W-1:0]       sel_min;

  assign done_eff = lane_done_i & busy_q;

  crack_min_sel #(
    .LANES (LANES),
    .KEY_W (KEY_W)
  ) u_min_sel (
    .done_i    (done_eff),
    .match_i   (lane_match_i),
    .keys_i    (inflight_q),
    .any_o     (sel_any),
    .min_key_o (sel_min)
  );

  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    busy_d       = busy_q;
    inflight_d   = inflight_q;
    cand_d       = cand_q;
    cand_valid_d = cand_valid_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    lane_en_o    = '0;

    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d      = ST_RUN;
          next_key_d   = '0;
          busy_d       = '0;
          cand_d       = '0;
          cand_valid_d = 1'b0;
          key_d        = '0;
          key_valid_d  = 1'b0;
        end
      end

      ST_RUN, ST_DRAIN: begin
        busy_d = busy_q & ~done_eff;
        if (sel_any && (!cand_valid_q || (sel_min < cand_q))) begin
          cand_d       = sel_min;
          cand_valid_d = 1'b1;
        end

        // Dispatch uses busy_q, so a lane finishing this cycle is only
        // re-dispatched next cycle. Nothing is handed out in a cycle that
        // brings a match: any newly dispatched key would be larger anyway.
        if ((state_q == ST_RUN) && !sel_any) begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_rdy_i[i] && !busy_q[i] && !next_key_d[KEY_W]) begin
              lane_en_o[i]                 = 1'b1;
              inflight_d[i*KEY_W +: KEY_W] = next_key_d[KEY_W-1:0];
              busy_d[i]                    = 1'b1;
              next_key_d                   = next_key_d + (KEY_W+1)'(1);
            end
          end
        end

        if ((state_q == ST_DRAIN) || sel_any || next_key_d[KEY_W]) begin
          if (busy_d == '0) begin
            state_d     = ST_IDLE;
            key_d       = cand_valid_d ? cand_d : '0;
            key_valid_d = cand_valid_d;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      next_key_q   <= '0;
      busy_q       <= '0;
      inflight_q   <= '0;
      cand_q       <= '0;
      cand_valid_q <= 1'b0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_key_q   <= next_key_d;
      busy_q       <= busy_d;
      inflight_q   <= inflight_d;
      cand_q       <= cand_d;
      cand_valid_q <= cand_valid_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
    end
  end

  assign rdy_o       = (state_q == ST_IDLE);
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  // The per-lane key register drives the lane; in the dispatch cycle the
  // key about to be stored is forwarded so it is valid with lane_en_o.
  assign lane_key_o  = inflight_d;

`ifdef CRACK_PERF_EN
  logic [KEY_W:0] tried_q, tried_d;

  always_comb begin
    tried_d = tried_q;
    if ((state_q == ST_IDLE) && en_i) begin
      tried_d = '0;
    end else begin
      tried_d = tried_q + (KEY_W+1)'($countones(lane_en_o));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tried_q <= '0;
    end else begin
      tried_q <= tried_d;
    end
  end

  assign keys_tried_o = tried_q;
`endif

`ifndef SYNTHESIS
  // A verdict from a lane with nothing outstanding points at a broken lane.
  // Strobes while idle are legitimate leftovers of a reset search.
  always @(posedge clk) begin
    if (!rst && (state_q != ST_IDLE)) begin
      assert ((lane_done_i & ~busy_q) == '0)
        else $error("crack_multi_ctrl: lane_done on a lane with no key in flight");
    end
  end
`endif

endmodule : crack_multi_ctrl
`default_nettype wire
